store_serializer: RTL and testbench

- Store-side counterpart of the load extender.
- Takes a 32-bit register value plus an access size (byte, halfword or word) and writes the selected bytes, one byte per transaction, to the byte-wide data memory.
- Memory handshake: mem_we / mem_ack.
- Sits between the execute/memory stage control and the data RAM. Byte order is big-endian: the most significant byte of the stored quantity goes to the lowest address.

---
 rtl/store_serializer.sv | 112 +++++++++++
 tb/tb_store_serializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/store_serializer.sv
// Serializes a byte/halfword/word register value into big-endian byte writes
// to a byte-wide data memory using a we/ack handshake.
module store_serializer #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       data_in,
  input  logic [1:0]        size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        last_q;
  logic [1:0]        cnt, cnt_nx;
  logic              err_q;
  logic              req_ok;
  logic [1:0]        last_in;
  logic [1:0]        pos;
  logic              accept;

  // Decode byte count (as last index) and alignment of the incoming request.
  always_comb begin
    last_in = 2'd0;
    req_ok  = 1'b0;
    case (size)
      2'd0: begin
        last_in = 2'd0;
        req_ok  = 1'b1;
      end
      2'd1: begin
        last_in = 2'd1;
        req_ok  = ~addr_in[0];
      end
      2'd2: begin
        last_in = 2'd3;
        req_ok  = (addr_in[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  assign accept = start_valid && (state == IDLE);
  // Big-endian: the first byte sent is the most significant of the quantity.
  assign pos    = last_q - cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      last_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q <= addr_in;
        data_q <= data_in;
        last_q <= last_in;
        err_q  <= ~req_ok;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    start_ready = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        start_ready = ~reset;
        if (start_valid) state_nx = req_ok ? WRITE : DONE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        mem_addr = addr_q + ADDR_W'(cnt);
        mem_data = data_q[{pos, 3'b000} +: 8];
        if (mem_ack) begin
          if (cnt == last_q) state_nx = DONE;
          else               cnt_nx   = cnt + 2'd1;
        end
      end
      DONE: begin
        done     = 1'b1;
        err      = err_q;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_serializer.sv
// Directed self-checking bench for store_serializer: vector table plus
// hand-written reset, reset-with-request and back-to-back sequences.
module tb_store_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [8:0]  addr_in;
  logic [31:0] data_in;
  logic [1:0]  size;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_ack;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  store_serializer #(.ADDR_W(9)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .addr_in(addr_in), .data_in(data_in), .size(size),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
    .done(done), .err(err)
  );

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          wt;     // extra ack-low cycles per byte
    logic        rej;
    int          n;
    logic [31:0] exp;    // expected bytes in write order, from bit 31 down
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts at the cycle following acceptance; ends at a negedge in IDLE.
  task automatic expect_body(input logic [8:0] addr, input logic [31:0] bytes,
                             input int n, input int wt, input logic rej);
    logic [31:0] b;
    logic [8:0]  a;
    if (rej) begin
      @(negedge clk);
      check("rej_done", done, 1);
      check("rej_err", err, 1);
      check("rej_we", mem_we, 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        b = bytes << (8 * i);
        a = addr + 9'(i);
        for (int w = 0; w <= wt; w++) begin
          @(negedge clk);
          check("we", mem_we, 1);
          check("addr", 32'(mem_addr), 32'(a));
          check("data", 32'(mem_data), 32'(b[31:24]));
          check("busy_done", done, 0);
          check("busy_ready", start_ready, 0);
          mem_ack = (w == wt);
        end
      end
      @(negedge clk);
      check("done", done, 1);
      check("err", err, 0);
      check("done_we", mem_we, 0);
      check("done_ready", start_ready, 0);
      mem_ack = 1'b1;
    end
    @(negedge clk);
    check("idle_ready", start_ready, 1);
    check("idle_done", done, 0);
    check("idle_err", err, 0);
    check("idle_we", mem_we, 0);
  endtask

  task automatic do_store(input vec_t v);
    @(negedge clk);
    addr_in = v.addr; data_in = v.data; size = v.size; start_valid = 1'b1;
    check("ready_before", start_ready, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    addr_in = ~v.addr; data_in = ~v.data; size = v.size ^ 2'd1;
    expect_body(v.addr, v.exp, v.n, v.wt, v.rej);
  endtask

  initial begin
    vecs[0] = '{addr: 9'h010, data: 32'hA1B2C3D4, size: 2'd2, wt: 0, rej: 1'b0, n: 4, exp: 32'hA1B2C3D4};
    vecs[1] = '{addr: 9'h022, data: 32'hFFFF8765, size: 2'd1, wt: 2, rej: 1'b0, n: 2, exp: 32'h87650000};
    vecs[2] = '{addr: 9'h1FF, data: 32'h123456EE, size: 2'd0, wt: 0, rej: 1'b0, n: 1, exp: 32'hEE000000};
    vecs[3] = '{addr: 9'h012, data: 32'h11111111, size: 2'd2, wt: 0, rej: 1'b1, n: 0, exp: 32'h0};
    vecs[4] = '{addr: 9'h013, data: 32'h22222222, size: 2'd1, wt: 0, rej: 1'b1, n: 0, exp: 32'h0};
    vecs[5] = '{addr: 9'h020, data: 32'h33333333, size: 2'd3, wt: 0, rej: 1'b1, n: 0, exp: 32'h0};
    vecs[6] = '{addr: 9'h1FC, data: 32'h01020304, size: 2'd2, wt: 1, rej: 1'b0, n: 4, exp: 32'h01020304};
    vecs[7] = '{addr: 9'h1FE, data: 32'hCAFEBABE, size: 2'd1, wt: 0, rej: 1'b0, n: 2, exp: 32'hBABE0000};

    reset = 1'b1; start_valid = 1'b0; addr_in = '0; data_in = '0; size = '0; mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", start_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", start_ready, 1);
    check("post_rst_addr", 32'(mem_addr), 0);
    check("post_rst_data", 32'(mem_data), 0);
    check("post_rst_err", err, 0);

    for (int k = 0; k < 8; k++) do_store(vecs[k]);

    // Reset after the second byte of a word is acknowledged.
    @(negedge clk);
    addr_in = 9'h040; data_in = 32'h11223344; size = 2'd2; start_valid = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(negedge clk);
    check("rw_b0_addr", 32'(mem_addr), 32'h040);
    check("rw_b0_data", 32'(mem_data), 32'h11);
    @(negedge clk);
    check("rw_b1_addr", 32'(mem_addr), 32'h041);
    check("rw_b1_data", 32'(mem_data), 32'h22);
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rw_we", mem_we, 0);
    check("rw_done", done, 0);
    reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    check("rw_ready", start_ready, 1);
    check("rw_done2", done, 0);
    do_store('{addr: 9'h055, data: 32'h000000C3, size: 2'd0, wt: 0, rej: 1'b0, n: 1, exp: 32'hC3000000});

    // Reset coinciding with a request drops the request.
    @(negedge clk);
    addr_in = 9'h060; data_in = 32'h99999999; size = 2'd0; start_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start_valid = 1'b0;
    check("rsv_we", mem_we, 0);
    @(negedge clk);
    check("rsv_we2", mem_we, 0);
    check("rsv_done", done, 0);
    check("rsv_ready", start_ready, 1);

    // Back-to-back: start_valid held high across two word stores.
    @(negedge clk);
    addr_in = 9'h080; data_in = 32'hDEADBEEF; size = 2'd2; start_valid = 1'b1;
    @(posedge clk); #1;
    addr_in = 9'h084; data_in = 32'h55667788;
    expect_body(9'h080, 32'hDEADBEEF, 4, 0, 1'b0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    expect_body(9'h084, 32'h55667788, 4, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
